// File: rtl/lfsr_bank.sv
// Bank of CHANNELS independent XNOR-feedback Fibonacci LFSRs that share one advance enable,
// with a two-state load port for reseeding one channel and sticky per-channel lock-up flags.
module lfsr_bank #(
    parameter int               WIDTH    = 32,
    parameter int               CHANNELS = 4,
    parameter logic [WIDTH-1:0] TAPS     = 32'h8020_0003,
    parameter logic [WIDTH-1:0] SEED     = 32'hABCC_6EFE,
    parameter int               STEPS    = 1,
    parameter int               STRIDE   = 5,
    localparam int              CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [CW-1:0]             load_chan,
    input  logic [WIDTH-1:0]          load_data,
    output logic [CHANNELS*WIDTH-1:0] rnd_out,
    output logic                      rnd_valid,
    output logic [CHANNELS-1:0]       lockup_flag,
    input  logic                      flag_clr
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } load_state_e;

    load_state_e                        state_q, state_d;
    logic [CW-1:0]                      chan_q, chan_d;
    logic [WIDTH-1:0]                   data_q, data_d;
    logic [CHANNELS-1:0][WIDTH-1:0]     lfsr_q, lfsr_d;
    logic [CHANNELS-1:0]                lockup_q, lockup_d;
    logic [CHANNELS-1:0]                lock_set;
    logic                               valid_q, valid_d;
    logic                               write_en;

    // Per-channel reset seed: SEED rotated left by k*STRIDE, never the all-ones lock-up value.
    function automatic logic [WIDTH-1:0] seed_of(input int k);
        int               r;
        logic [WIDTH-1:0] s;
        r = (k * STRIDE) % WIDTH;
        s = (SEED << r) | (SEED >> (WIDTH - r));
        if (&s) s[0] = 1'b0;
        return s;
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] t;
        t = s;
        for (int i = 0; i < STEPS; i++) begin
            t = {t[WIDTH-2:0], ~^(t & TAPS)};
        end
        return t;
    endfunction

    // Load FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            chan_q  <= '0;
            data_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
            chan_q  <= chan_d;
            data_q  <= data_d;
        end
    end

    // Load FSM: next state
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    state_d = WRITE;
                    chan_d  = load_chan;
                    data_d  = load_data;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Load FSM: outputs
    always_comb begin
        load_ready = (state_q == IDLE);
        write_en   = (state_q == WRITE);
    end

    // Channel datapath; an out-of-range captured channel never matches any k and is dropped.
    always_comb begin
        lfsr_d   = lfsr_q;
        lock_set = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (en) lfsr_d[k] = advance(lfsr_q[k]);
            if (write_en && (int'(chan_q) == k)) lfsr_d[k] = data_q;
            if (&lfsr_d[k]) begin
                lfsr_d[k]   = seed_of(k);
                lock_set[k] = 1'b1;
            end
        end
        lockup_d = (lockup_q & ~{CHANNELS{flag_clr}}) | lock_set;
        valid_d  = en;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < CHANNELS; k++) begin
                lfsr_q[k] <= seed_of(k);
            end
            lockup_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_d;
            lockup_q <= lockup_d;
            valid_q  <= valid_d;
        end
    end

    assign rnd_out     = lfsr_q;
    assign rnd_valid   = valid_q;
    assign lockup_flag = lockup_q;

endmodule
